// File: rtl/pwm_generator_multi.sv
// pwm_generator_multi
//   NUM_CH independent PWM channels sharing one period counter. Each channel
//   has debounced increase/decrease buttons driving a saturating shadow duty
//   register. The shadow duty is copied to the active duty only at the period
//   boundary, so a period in progress is never cut short or stretched.
//   Output alignment is edge or centre, latched at the same boundary.
//
// Ports
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   increase_duty  raw increase button per channel (bit i = channel i)
//   decrease_duty  raw decrease button per channel
//   center_mode    0 = edge-aligned, 1 = centre-aligned (latched at wrap)
//   pwm_out        registered PWM outputs, lag pwm_cnt by one cycle
//   duty_out       shadow duty per channel, channel i at [i*CNT_W +: CNT_W]
//   period_wrap    high while the period counter sits at PERIOD-1
module pwm_generator_multi #(
  parameter int NUM_CH    = 4,
  parameter int CNT_W     = 8,
  parameter int PERIOD    = 10,
  parameter int STEP      = 1,
  parameter int DUTY_INIT = 5,
  parameter int DEB_DIV   = 25000000,
  parameter int DEB_W     = 28
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       increase_duty,
  input  logic [NUM_CH-1:0]       decrease_duty,
  input  logic                    center_mode,
  output logic [NUM_CH-1:0]       pwm_out,
  output logic [NUM_CH*CNT_W-1:0] duty_out,
  output logic                    period_wrap
);

  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W:0]   PERIOD_X = (CNT_W+1)'(PERIOD);
  localparam logic [CNT_W:0]   STEP_X   = (CNT_W+1)'(STEP);
  localparam logic [CNT_W-1:0] DUTY_RST = CNT_W'(DUTY_INIT);

  logic [DEB_W-1:0]  deb_cnt;
  logic              slow_en;
  logic [NUM_CH-1:0] inc_s1, inc_s2, dec_s1, dec_s2;
  logic [NUM_CH-1:0] inc_press, dec_press;
  logic [CNT_W-1:0]  shadow_q [NUM_CH];
  logic [CNT_W-1:0]  shadow_d [NUM_CH];
  logic [CNT_W-1:0]  active_q [NUM_CH];
  logic [CNT_W-1:0]  pwm_cnt;
  logic              mode_q;

  // Next shadow duty. Arithmetic is one bit wider than the register so the
  // increment cannot wrap before it is clamped to PERIOD.
  function automatic logic [CNT_W-1:0] next_duty(input logic [CNT_W-1:0] duty,
                                                  input logic inc,
                                                  input logic dec);
    logic [CNT_W:0] wide;
    logic [CNT_W:0] sum;
    wide = {1'b0, duty};
    sum  = wide + STEP_X;
    next_duty = duty;
    if (inc && !dec) begin
      next_duty = (sum > PERIOD_X) ? PERIOD_X[CNT_W-1:0] : sum[CNT_W-1:0];
    end else if (dec && !inc) begin
      next_duty = (wide < STEP_X) ? '0 : (wide - STEP_X) ;
    end
  endfunction

  // Compare for one channel. Centre mode places the high window so that its
  // width is still exactly duty clocks; odd slack puts the extra low clock
  // at the end of the period.
  function automatic logic pwm_bit(input logic [CNT_W-1:0] cnt,
                                   input logic [CNT_W-1:0] duty,
                                   input logic centre);
    logic [CNT_W:0] c, d, lo, hi;
    c  = {1'b0, cnt};
    d  = {1'b0, duty};
    lo = (PERIOD_X - d) >> 1;
    hi = lo + d;
    if (centre) pwm_bit = (c >= lo) && (c < hi);
    else        pwm_bit = (c < d);
  endfunction

  // Slow enable for debouncing.
  assign slow_en = (deb_cnt == DEB_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       deb_cnt <= '0;
    else if (slow_en) deb_cnt <= '0;
    else              deb_cnt <= deb_cnt + DEB_W'(1);
  end

  // Button samplers only move on slow_en, so a held button produces exactly
  // one rising pair (s1=1, s2=0) and therefore one press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inc_s1 <= '0;
      inc_s2 <= '0;
      dec_s1 <= '0;
      dec_s2 <= '0;
    end else if (slow_en) begin
      inc_s1 <= increase_duty;
      inc_s2 <= inc_s1;
      dec_s1 <= decrease_duty;
      dec_s2 <= dec_s1;
    end
  end

  assign inc_press = inc_s1 & ~inc_s2 & {NUM_CH{slow_en}};
  assign dec_press = dec_s1 & ~dec_s2 & {NUM_CH{slow_en}};

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      shadow_d[i] = next_duty(shadow_q[i], inc_press[i], dec_press[i]);
    end
  end

  // Shared period counter.
  assign period_wrap = (pwm_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           pwm_cnt <= '0;
    else if (period_wrap) pwm_cnt <= '0;
    else                  pwm_cnt <= pwm_cnt + CNT_W'(1);
  end

  // Shadow, active duty and mode. Active copies only at the boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        shadow_q[i] <= DUTY_RST;
        active_q[i] <= DUTY_RST;
      end
      mode_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        shadow_q[i] <= shadow_d[i];
        if (period_wrap) active_q[i] <= shadow_q[i];
      end
      if (period_wrap) mode_q <= center_mode;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_out <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        pwm_out[i] <= pwm_bit(pwm_cnt, active_q[i], mode_q);
      end
    end
  end

  always_comb begin
    duty_out = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      duty_out[i*CNT_W +: CNT_W] = shadow_q[i];
    end
  end

endmodule

// File: tb/tb_pwm_generator_multi.sv
// Directed bench for pwm_generator_multi with NUM_CH=2, PERIOD=10, STEP=1,
// DUTY_INIT=5, DEB_DIV=2, CNT_W=8. Outputs are sampled on the falling edge.
// Captured period patterns hold bit i = pwm_out for pwm_cnt = i.
module tb_pwm_generator_multi;

  logic        clk;
  logic        rst_n;
  logic [1:0]  increase_duty;
  logic [1:0]  decrease_duty;
  logic        center_mode;
  logic [1:0]  pwm_out;
  logic [15:0] duty_out;
  logic        period_wrap;

  int tests_run = 0;
  int fails     = 0;

  logic [9:0] p0, p1, w;

  pwm_generator_multi #(
    .NUM_CH(2), .CNT_W(8), .PERIOD(10), .STEP(1),
    .DUTY_INIT(5), .DEB_DIV(2), .DEB_W(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .increase_duty(increase_duty),
    .decrease_duty(decrease_duty),
    .center_mode(center_mode),
    .pwm_out(pwm_out),
    .duty_out(duty_out),
    .period_wrap(period_wrap)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, run %0d failed %0d", tests_run, fails);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Leaves the bench on the falling edge where pwm_cnt = PERIOD-1.
  task automatic wait_wrap();
    int n;
    n = 0;
    @(negedge clk);
    while (period_wrap !== 1'b1 && n < 25) begin
      @(negedge clk);
      n++;
    end
    check("wrap_found", {31'd0, period_wrap}, 32'd1);
  endtask

  // Records one whole period of both outputs and period_wrap.
  task automatic capture(output logic [9:0] c0, output logic [9:0] c1,
                         output logic [9:0] cw);
    wait_wrap();
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      c0[i] = pwm_out[0];
      c1[i] = pwm_out[1];
      cw[i] = period_wrap;
    end
  endtask

  task automatic press(input int ch, input logic inc, input logic dec);
    @(negedge clk);
    increase_duty[ch] = inc;
    decrease_duty[ch] = dec;
    repeat (8) @(negedge clk);
    increase_duty = '0;
    decrease_duty = '0;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    rst_n         = 1'b0;
    increase_duty = '0;
    decrease_duty = '0;
    center_mode   = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_pwm",  {30'd0, pwm_out}, 32'd0);
    check("rst_duty", {16'd0, duty_out}, 32'h0505);
    check("rst_wrap", {31'd0, period_wrap}, 32'd0);

    // 1: idle, 5/10 on both channels, first high one clock after cnt=0
    rst_n = 1'b1;
    @(negedge clk);
    check("t1_first_high", {30'd0, pwm_out}, 32'h3);
    capture(p0, p1, w);
    check("t1_ch0", {22'd0, p0}, 32'h01F);
    check("t1_ch1", {22'd0, p1}, 32'h01F);
    check("t1_wrap", {22'd0, w}, 32'h100);

    // 2: held increase on ch0 mid-period, change waits for the boundary
    wait_wrap();
    @(negedge clk);
    increase_duty[0] = 1'b1;
    repeat (6) @(negedge clk);
    check("t2_shadow_mid", {16'd0, duty_out}, 32'h0506);
    check("t2_old_width", {31'd0, pwm_out[0]}, 32'd0);
    repeat (14) @(negedge clk);
    increase_duty = '0;
    repeat (8) @(negedge clk);
    check("t2_once", {16'd0, duty_out}, 32'h0506);
    capture(p0, p1, w);
    check("t2_ch0", {22'd0, p0}, 32'h03F);
    check("t2_ch1", {22'd0, p1}, 32'h01F);

    // 3: saturate ch1 at PERIOD, then drain to 0 without wrapping
    for (int k = 0; k < 7; k++) press(1, 1'b1, 1'b0);
    check("t3_sat_hi", {16'd0, duty_out}, 32'h0A06);
    capture(p0, p1, w);
    check("t3_ch1_high", {22'd0, p1}, 32'h3FF);
    check("t3_ch0_keep", {22'd0, p0}, 32'h03F);
    for (int k = 0; k < 12; k++) press(1, 1'b0, 1'b1);
    check("t3_sat_lo", {16'd0, duty_out}, 32'h0006);
    capture(p0, p1, w);
    check("t3_ch1_low", {22'd0, p1}, 32'h000);

    // 4: both buttons together, no change
    press(0, 1'b1, 1'b1);
    check("t4_both", {16'd0, duty_out}, 32'h0006);

    // 5: centre mode, ch0 duty 4 -> high for cnt 3..6
    press(0, 1'b0, 1'b1);
    press(0, 1'b0, 1'b1);
    check("t5_duty4", {16'd0, duty_out}, 32'h0004);
    center_mode = 1'b1;
    capture(p0, p1, w);
    check("t5_centre", {22'd0, p0}, 32'h078);
    check("t5_ch1", {22'd0, p1}, 32'h000);
    wait_wrap();
    @(negedge clk);
    center_mode = 1'b0;
    repeat (2) @(negedge clk);
    check("t5_mid_cnt1", {31'd0, pwm_out[0]}, 32'd0);
    repeat (5) @(negedge clk);
    check("t5_mid_cnt6", {31'd0, pwm_out[0]}, 32'd1);
    capture(p0, p1, w);
    check("t5_edge_back", {22'd0, p0}, 32'h00F);

    // 6: asynchronous reset mid-period with ch0 duty 8
    for (int k = 0; k < 4; k++) press(0, 1'b1, 1'b0);
    check("t6_duty8", {16'd0, duty_out}, 32'h0008);
    wait_wrap();
    @(negedge clk);
    repeat (3) @(negedge clk);
    check("t6_pre_high", {30'd0, pwm_out}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_pwm",  {30'd0, pwm_out}, 32'd0);
    check("t6_async_duty", {16'd0, duty_out}, 32'h0505);
    check("t6_async_wrap", {31'd0, period_wrap}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_restart", {30'd0, pwm_out}, 32'h3);
    check("t6_duty_rel", {16'd0, duty_out}, 32'h0505);
    repeat (7) @(negedge clk);
    check("t6_no_wrap8", {31'd0, period_wrap}, 32'd0);
    @(negedge clk);
    check("t6_wrap9", {31'd0, period_wrap}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
